// File: rtl/fetch_ctrl.sv
// Fetch sequencing/hazard controller: merges EX branch, ID jump, load-use and halt
// requests into fetch-unit controls, with a post-reset boot hold-off and perf counters.
module fetch_ctrl #(
    parameter int unsigned                  ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0]        BOOT_VEC     = '0,
    parameter int unsigned                  BOOT_CYCLES  = 2,
    parameter int unsigned                  FLUSH_CYCLES = 2,
    parameter int unsigned                  CNT_WIDTH    = 16
) (
    input  logic                  clk_87,
    input  logic                  rst_n_87,
    input  logic                  ex_br_taken_87,
    input  logic [ADDR_WIDTH-1:0] ex_br_tgt_87,
    input  logic                  id_jump_87,
    input  logic [ADDR_WIDTH-1:0] id_jump_tgt_87,
    input  logic                  ex_memrd_87,
    input  logic [4:0]            ex_rt_87,
    input  logic [4:0]            id_rs_87,
    input  logic [4:0]            id_rt_87,
    input  logic                  id_uses_rt_87,
    input  logic                  halt_req_87,
    input  logic                  resume_87,
    output logic [ADDR_WIDTH-1:0] pc_87,
    output logic                  sel_87,
    output logic                  stall_87,
    output logic                  flush_87,
    output logic                  bubble_87,
    output logic                  halted_87,
    output logic [CNT_WIDTH-1:0]  stall_cnt_87,
    output logic [CNT_WIDTH-1:0]  flush_cnt_87
);

    localparam logic [3:0]           BootLoad  = 4'(BOOT_CYCLES);
    localparam logic [1:0]           FlushLoad = 2'(FLUSH_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CntOne    = CNT_WIDTH'(1);

    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

    state_e               state_q;
    logic [3:0]           boot_q;
    logic [1:0]           flush_q;
    logic                 hz_q;
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] flush_cnt_q;

    logic in_run, in_halt, boot_last, flushing;
    logic hz_raw, br_acc, jmp_acc, hz_acc, halt_acc;

    always_comb begin
        in_run    = (state_q == StRun);
        in_halt   = (state_q == StHalt);
        boot_last = (state_q == StBoot) && (boot_q == 4'd1);
        flushing  = (flush_q != 2'd0);
        hz_raw    = ex_memrd_87 && (ex_rt_87 != 5'd0) &&
                    ((ex_rt_87 == id_rs_87) || (id_uses_rt_87 && (ex_rt_87 == id_rt_87)));
        br_acc    = in_run && ex_br_taken_87;
        // ID-stage requests come from a squashed path while flushing
        jmp_acc   = in_run && id_jump_87 && !ex_br_taken_87 && !flushing;
        // hz_q limits a held hazard to a single stall cycle
        hz_acc    = in_run && hz_raw && !ex_br_taken_87 && !jmp_acc && !flushing && !hz_q;
        halt_acc  = in_run && halt_req_87 && !br_acc && !jmp_acc && !flushing;
    end

    always_comb begin
        sel_87 = br_acc || jmp_acc || boot_last;
        if (br_acc) begin
            pc_87 = ex_br_tgt_87;
        end else if (jmp_acc) begin
            pc_87 = id_jump_tgt_87;
        end else if (boot_last) begin
            pc_87 = BOOT_VEC;
        end else begin
            pc_87 = '0;
        end
        stall_87     = ((state_q == StBoot) && !boot_last) || in_halt || hz_acc;
        bubble_87    = hz_acc;
        flush_87     = flushing;
        halted_87    = in_halt;
        stall_cnt_87 = stall_cnt_q;
        flush_cnt_87 = flush_cnt_q;
    end

    always_ff @(posedge clk_87 or negedge rst_n_87) begin
        if (!rst_n_87) begin
            state_q     <= StBoot;
            boot_q      <= BootLoad;
            flush_q     <= 2'd0;
            hz_q        <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            hz_q <= hz_acc;
            if (br_acc) begin
                flush_q <= FlushLoad;
            end else if (jmp_acc) begin
                flush_q <= 2'd1;
            end else if (flushing) begin
                flush_q <= flush_q - 2'd1;
            end
            if (stall_87 && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CntOne;
            end
            if ((br_acc || jmp_acc) && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CntOne;
            end
            unique case (state_q)
                StBoot: begin
                    if (boot_last) begin
                        state_q <= StRun;
                    end else begin
                        boot_q <= boot_q - 4'd1;
                    end
                end
                StRun: begin
                    if (halt_acc) begin
                        state_q <= StHalt;
                    end
                end
                StHalt: begin
                    if (resume_87) begin
                        state_q <= StRun;
                    end
                end
                default: state_q <= StBoot;
            endcase
        end
    end

endmodule
